// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction fetch sequencer with registered decode slot, redirect and fault handling.
// Optional debug read port on the instruction memory enabled by defining IFETCH_DBG_EN.
module ifetch_ctrl #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          MEM_BYTES = 512,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [63:0] if_pc,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        fault,
   output logic [63:0] fault_pc
`ifdef IFETCH_DBG_EN
   ,
   input  logic        dbg_req,
   input  logic [63:0] dbg_addr,
   output logic        dbg_gnt,
   output logic [31:0] dbg_rdata
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [63:0] r_pc;
   logic [63:0] w_pc_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic [63:0] r_if_pc;
   logic [63:0] w_if_pc_nxt;
   logic        r_fault;
   logic        w_fault_nxt;
   logic [63:0] r_fault_pc;
   logic [63:0] w_fault_pc_nxt;

   logic        w_gnt;
   logic        w_slot_free;
   logic        w_pc_legal;

`ifdef IFETCH_DBG_EN
   logic [1:0]  r_dbg_cnt;
   logic [1:0]  w_dbg_cnt_nxt;

   // After two back-to-back grants the fetch side is guaranteed one cycle on the port.
   assign w_gnt         = rst_n & dbg_req & ~redirect_valid & (r_dbg_cnt != 2'd2);
   assign w_dbg_cnt_nxt = w_gnt ? (r_dbg_cnt + 2'd1) : 2'd0;
   assign dbg_gnt       = w_gnt;
   assign dbg_rdata     = w_gnt ? imem_instr : 32'h0;
   assign imem_addr     = w_gnt ? dbg_addr : r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dbg_cnt <= 2'd0;
      end else begin
         r_dbg_cnt <= w_dbg_cnt_nxt;
      end
   end
`else
   assign w_gnt     = 1'b0;
   assign imem_addr = r_pc;
`endif

   assign w_slot_free = ~r_valid | id_ready;
   assign w_pc_legal  = (r_pc[1:0] == 2'b00) && (r_pc <= LAST_PC);

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_valid_nxt    = r_valid;
      w_instr_nxt    = r_instr;
      w_if_pc_nxt    = r_if_pc;
      w_fault_nxt    = r_fault;
      w_fault_pc_nxt = r_fault_pc;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_RUN;
         end
         S_RUN, S_FAULT: begin
            if (redirect_valid) begin
               w_pc_nxt    = redirect_pc;
               w_valid_nxt = 1'b0;
               w_instr_nxt = NOP_INSTR;
               w_fault_nxt = 1'b0;
               w_state_nxt = S_RUN;
            end else if (!w_gnt && w_slot_free) begin
               if (r_state == S_RUN && w_pc_legal) begin
                  w_valid_nxt = 1'b1;
                  w_instr_nxt = imem_instr;
                  w_if_pc_nxt = r_pc;
                  w_pc_nxt    = r_pc + 64'd4;
               end else begin
                  // Slot drains; a RUN-state attempt on a bad PC is what raises the fault.
                  w_valid_nxt = 1'b0;
                  w_instr_nxt = NOP_INSTR;
                  if (r_state == S_RUN) begin
                     w_fault_nxt    = 1'b1;
                     w_fault_pc_nxt = r_pc;
                     w_state_nxt    = S_FAULT;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_valid    <= 1'b0;
         r_instr    <= NOP_INSTR;
         r_if_pc    <= 64'h0;
         r_fault    <= 1'b0;
         r_fault_pc <= 64'h0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_valid    <= w_valid_nxt;
         r_instr    <= w_instr_nxt;
         r_if_pc    <= w_if_pc_nxt;
         r_fault    <= w_fault_nxt;
         r_fault_pc <= w_fault_pc_nxt;
      end
   end

   assign if_valid = r_valid;
   assign if_instr = r_instr;
   assign if_pc    = r_if_pc;
   assign fault    = r_fault;
   assign fault_pc = r_fault_pc;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl: directed vector table plus randomized run against a reference model.
module tb_ifetch_ctrl;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        id_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        fault;
   logic [63:0] fault_pc;
`ifdef IFETCH_DBG_EN
   logic        dbg_req = 1'b0;
   logic [63:0] dbg_addr = 64'h0;
   logic        dbg_gnt;
   logic [31:0] dbg_rdata;
   logic        seen_gnt;
`endif

   logic [31:0] mem [128];

   int n_chk = 0;
   int n_fail = 0;

   // behavioural reference state
   int          m_mode;
   logic [63:0] m_pc;
   logic        m_v;
   logic [31:0] m_instr;
   logic [63:0] m_ifpc;
   logic        m_f;
   logic [63:0] m_fpc;
   int          m_cnt;

   typedef struct {
      bit          rdy;
      bit          rv;
      logic [63:0] rpc;
      bit          ev;
      logic [63:0] epc;
      bit          ef;
      logic [63:0] efpc;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [31:0] memrd(input logic [63:0] a);
      if (a < 64'd512) return mem[a[8:2]];
      return 32'hDEADBEEF;
   endfunction

   assign imem_instr = memrd(imem_addr);

   ifetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fault          (fault),
      .fault_pc       (fault_pc)
`ifdef IFETCH_DBG_EN
      ,
      .dbg_req        (dbg_req),
      .dbg_addr       (dbg_addr),
      .dbg_gnt        (dbg_gnt),
      .dbg_rdata      (dbg_rdata)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_pc    = 64'h0;
      m_v     = 1'b0;
      m_instr = NOP;
      m_ifpc  = 64'h0;
      m_f     = 1'b0;
      m_fpc   = 64'h0;
      m_cnt   = 0;
   endtask

   function automatic bit model_gnt();
`ifdef IFETCH_DBG_EN
      return dbg_req && !redirect_valid && (m_cnt != 2);
`else
      return 1'b0;
`endif
   endfunction

   // One clock of the fetch rules: modes 0=idle 1=running 2=faulted.
   task automatic model_step();
      bit g;
      g = model_gnt();
      m_cnt = g ? m_cnt + 1 : 0;
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (redirect_valid) begin
         m_pc = redirect_pc; m_v = 1'b0; m_instr = NOP; m_f = 1'b0; m_mode = 1;
      end else if (!g && (!m_v || id_ready)) begin
         if (m_mode == 1 && (m_pc % 4 == 0) && m_pc <= 64'd508) begin
            m_v = 1'b1; m_instr = memrd(m_pc); m_ifpc = m_pc; m_pc = m_pc + 4;
         end else begin
            m_v = 1'b0; m_instr = NOP;
            if (m_mode == 1) begin
               m_f = 1'b1; m_fpc = m_pc; m_mode = 2;
            end
         end
      end
   endtask

   task automatic check_regs();
      chk("if_valid", if_valid, m_v);
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ifpc);
      chk("fault", fault, m_f);
      chk("fault_pc", fault_pc, m_fpc);
   endtask

   // Called at posedge+1 with inputs already driven for the coming edge.
   task automatic tick();
      bit g;
      #4;
      g = model_gnt();
`ifdef IFETCH_DBG_EN
      seen_gnt = dbg_gnt;
      chk("dbg_gnt", dbg_gnt, g);
      chk("dbg_rdata", dbg_rdata, g ? memrd(dbg_addr) : 32'h0);
      chk("imem_addr", imem_addr, g ? dbg_addr : m_pc);
`else
      chk("imem_addr", imem_addr, m_pc);
`endif
      @(posedge clk);
      model_step();
      #1;
      check_regs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      id_ready = 1'b0;
      redirect_valid = 1'b0;
`ifdef IFETCH_DBG_EN
      dbg_req = 1'b0;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_regs();
      rst_n = 1'b1;
   endtask

   initial begin
      bit exp_pat [6];
      logic [63:0] prev_pc;
      for (int i = 0; i < 128; i++) mem[i] = 32'h40000000 + i * 32'h00010101;

      // directed table
      tbl.push_back('{1, 0, 64'h0,   0, 64'h0,   0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   1, 64'h0,   0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   1, 64'h4,   0, 64'h0});
      tbl.push_back('{0, 0, 64'h0,   1, 64'h4,   0, 64'h0});
      tbl.push_back('{0, 0, 64'h0,   1, 64'h4,   0, 64'h0});
      tbl.push_back('{0, 0, 64'h0,   1, 64'h4,   0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   1, 64'h8,   0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   1, 64'hC,   0, 64'h0});
      tbl.push_back('{0, 0, 64'h0,   1, 64'hC,   0, 64'h0});
      tbl.push_back('{0, 1, 64'h40,  0, 64'h0,   0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   1, 64'h40,  0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   1, 64'h44,  0, 64'h0});
      tbl.push_back('{1, 1, 64'h1F8, 0, 64'h0,   0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   1, 64'h1F8, 0, 64'h0});
      tbl.push_back('{0, 0, 64'h0,   1, 64'h1F8, 0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   1, 64'h1FC, 0, 64'h0});
      tbl.push_back('{0, 0, 64'h0,   1, 64'h1FC, 0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   0, 64'h0,   1, 64'h200});
      tbl.push_back('{1, 0, 64'h0,   0, 64'h0,   1, 64'h200});
      tbl.push_back('{1, 1, 64'h2,   0, 64'h0,   0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   0, 64'h0,   1, 64'h2});
      tbl.push_back('{0, 1, 64'h0,   0, 64'h0,   0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   1, 64'h0,   0, 64'h0});
      tbl.push_back('{1, 0, 64'h0,   1, 64'h4,   0, 64'h0});

      do_reset();
      chk("reset_if_instr", if_instr, NOP);
      chk("reset_imem_addr", imem_addr, 64'h0);
      foreach (tbl[k]) begin
         id_ready = tbl[k].rdy;
         redirect_valid = tbl[k].rv;
         redirect_pc = tbl[k].rpc;
         tick();
         chk($sformatf("tbl%0d_valid", k), if_valid, tbl[k].ev);
         chk($sformatf("tbl%0d_instr", k), if_instr, tbl[k].ev ? memrd(tbl[k].epc) : NOP);
         if (tbl[k].ev) chk($sformatf("tbl%0d_pc", k), if_pc, tbl[k].epc);
         chk($sformatf("tbl%0d_fault", k), fault, tbl[k].ef);
         if (tbl[k].ef) chk($sformatf("tbl%0d_fault_pc", k), fault_pc, tbl[k].efpc);
      end
      redirect_valid = 1'b0;

`ifdef IFETCH_DBG_EN
      // steady fetch with id_ready=1, then hold a debug request for six cycles
      exp_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      id_ready = 1'b1;
      dbg_req = 1'b1;
      dbg_addr = 64'h100;
      for (int k = 0; k < 6; k++) begin
         prev_pc = if_pc;
         tick();
         chk($sformatf("dbg_pat%0d", k), seen_gnt, exp_pat[k]);
         chk($sformatf("dbg_adv%0d", k), if_pc, exp_pat[k] ? prev_pc : prev_pc + 64'd4);
      end
      dbg_req = 1'b0;
`else
      prev_pc = 64'h0;
      exp_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

      // randomized run with an asynchronous reset in the middle
      for (int c = 0; c < 400; c++) begin
         if (c == 200) begin
            #2;
            rst_n = 1'b0;
            #1;
            model_reset();
            check_regs();
            chk("async_imem_addr", imem_addr, 64'h0);
`ifdef IFETCH_DBG_EN
            chk("async_dbg_gnt", dbg_gnt, 1'b0);
            chk("async_dbg_rdata", dbg_rdata, 32'h0);
`endif
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
         id_ready = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0: redirect_pc = 64'($urandom_range(0, 127)) * 4;
            1: redirect_pc = 64'h1F0 + 64'($urandom_range(0, 3)) * 4;
            2: redirect_pc = 64'($urandom_range(0, 511));
            default: redirect_pc = {$urandom, $urandom};
         endcase
`ifdef IFETCH_DBG_EN
         dbg_req = ($urandom_range(0, 2) == 0);
         dbg_addr = 64'($urandom_range(0, 600));
`endif
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
